// File: rtl/seq_classifier.sv
// Classifies a W-bit sample stream against eight mod-2^W integer sequences and reports the survivor.
// Define SEQ_CLASSIFIER_PREDICT_EN to build the next-sample predictor behind pred_valid/pred_data.
module seq_classifier #(
   parameter int unsigned W          = 8,
   parameter logic [7:0]  CHECK_MASK = 8'hFF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic [7:0]   cand,
   output logic         locked,
   output logic [2:0]   seq_id,
   output logic         nomatch,
   output logic [1:0]   state,
   output logic         upd,
   output logic         pred_valid,
   output logic [W-1:0] pred_data
);
   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2, NOMATCH = 2'd3} state_t;

   localparam logic [W-1:0] V0 = '0;
   localparam logic [W-1:0] V1 = W'(1);
   localparam logic [W-1:0] V2 = W'(2);

   // Value sequence `id` must take given the seed phase, index and sample history.
   function automatic logic [W-1:0] expected(input logic [2:0]   id,
                                             input logic [1:0]   ph,
                                             input logic [W-1:0] k,
                                             input logic [W-1:0] h1,
                                             input logic [W-1:0] h2,
                                             input logic [W-1:0] h3);
      logic [W-1:0] r;
      case (id)
         3'd0:    r = k * k;
         3'd1:    r = (ph == 2'd0) ? V1 : h1 + h1 + h1;
         3'd2:    r = (ph == 2'd0) ? V0 : h1 + k;
         3'd3:    r = (ph <  2'd2) ? V1 : h1 + h2;
         3'd4:    r = (ph == 2'd0) ? V0 : (ph == 2'd1) ? V1 : h1 + h1 + h2;
         3'd5:    r = (ph == 2'd0) ? V2 : (ph == 2'd1) ? V1 : h1 + h2;
         3'd6:    r = (ph != 2'd3) ? V1 : h2 + h3;
         default: r = (ph == 2'd0) ? V2 : h1 * (h1 - V1) + V1;
      endcase
      return r;
   endfunction

   state_t       state_q, state_n;
   logic [W-1:0] k_q, h1_q, h2_q, h3_q;
   logic [W-1:0] k_b, h1_b, h2_b, h3_b;
   logic [1:0]   phase_q, phase_b, phase_n;
   logic [7:0]   cand_q, cand_b, cand_n;
   logic [2:0]   seq_id_q, seq_id_n;
   logic [3:0]   pop;
   logic         locked_q, nomatch_q, upd_q;

   // NOTE: every variable written here is assigned unconditionally first, so no latch can be inferred.
   always_comb begin
      // clear restarts the run at the same edge, so a coincident sample becomes index 0
      k_b     = clear ? V0 : k_q;
      h1_b    = clear ? V0 : h1_q;
      h2_b    = clear ? V0 : h2_q;
      h3_b    = clear ? V0 : h3_q;
      phase_b = clear ? 2'd0 : phase_q;
      cand_b  = clear ? CHECK_MASK : cand_q;
      phase_n = (phase_b == 2'd3) ? 2'd3 : phase_b + 2'd1;

      cand_n = cand_b;
      for (int i = 0; i < 8; i++) begin
         if (in_data != expected(3'(i), phase_b, k_b, h1_b, h2_b, h3_b))
            cand_n[i] = 1'b0;
      end

      pop      = 4'($countones(cand_n));
      seq_id_n = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (cand_n[i] && pop == 4'd1)
            seq_id_n = 3'(i);
      end

      if (pop == 4'd0)      state_n = NOMATCH;
      else if (pop == 4'd1) state_n = LOCKED;
      else                  state_n = TRACK;
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values together.
   always_ff @(posedge clk) begin
      if (reset) begin
         k_q       <= V0;
         phase_q   <= 2'd0;
         h1_q      <= V0;
         h2_q      <= V0;
         h3_q      <= V0;
         cand_q    <= CHECK_MASK;
         locked_q  <= 1'b0;
         seq_id_q  <= 3'd0;
         nomatch_q <= 1'b0;
         state_q   <= IDLE;
         upd_q     <= 1'b0;
      end else begin
         upd_q <= in_valid;
         if (in_valid) begin
            k_q       <= k_b + V1;
            phase_q   <= phase_n;
            h1_q      <= in_data;
            h2_q      <= h1_b;
            h3_q      <= h2_b;
            cand_q    <= cand_n;
            locked_q  <= (pop == 4'd1);
            nomatch_q <= (pop == 4'd0);
            seq_id_q  <= seq_id_n;
            state_q   <= state_n;
         end else if (clear) begin
            k_q       <= V0;
            phase_q   <= 2'd0;
            h1_q      <= V0;
            h2_q      <= V0;
            h3_q      <= V0;
            cand_q    <= CHECK_MASK;
            locked_q  <= 1'b0;
            seq_id_q  <= 3'd0;
            nomatch_q <= 1'b0;
            state_q   <= IDLE;
         end
      end
   end

   assign cand    = cand_q;
   assign locked  = locked_q;
   assign seq_id  = seq_id_q;
   assign nomatch = nomatch_q;
   assign state   = state_q;
   assign upd     = upd_q;

`ifdef SEQ_CLASSIFIER_PREDICT_EN
   logic [W-1:0] pred_q;

   // Prediction evaluates the same rule one step ahead using the post-update history.
   always_ff @(posedge clk) begin
      if (reset)
         pred_q <= V0;
      else if (in_valid)
         pred_q <= (pop == 4'd1) ? expected(seq_id_n, phase_n, k_b + V1, in_data, h1_b, h2_b) : V0;
      else if (clear)
         pred_q <= V0;
   end

   assign pred_valid = locked_q;
   assign pred_data  = pred_q;
`else
   assign pred_valid = 1'b0;
   assign pred_data  = V0;
`endif

endmodule

// File: tb/tb_seq_classifier.sv
// Bench for seq_classifier: two instances (full mask and 8'hF7) checked every cycle against a
// model built from tables of the true sequence values, plus literal expectations from worked examples.
module tb_seq_classifier;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1, clear = 1'b0, in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic [7:0] cand_a, cand_b, pd_a, pd_b;
   logic [2:0] seq_id_a, seq_id_b;
   logic [1:0] state_a, state_b;
   logic       locked_a, locked_b, nomatch_a, nomatch_b, upd_a, upd_b, pv_a, pv_b;

   always #5 clk = ~clk;

   seq_classifier #(.W(W), .CHECK_MASK(8'hFF)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .cand(cand_a), .locked(locked_a), .seq_id(seq_id_a), .nomatch(nomatch_a),
      .state(state_a), .upd(upd_a), .pred_valid(pv_a), .pred_data(pd_a));

   seq_classifier #(.W(W), .CHECK_MASK(8'hF7)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .cand(cand_b), .locked(locked_b), .seq_id(seq_id_b), .nomatch(nomatch_b),
      .state(state_b), .upd(upd_b), .pred_valid(pv_b), .pred_data(pd_b));

   int         checks = 0;
   int         errors = 0;
   int         term [8][1024];
   logic [7:0] masks [2] = '{8'hFF, 8'hF7};
   logic [7:0] alive [2];
   int         n_seen = 0;
   bit         exp_upd = 1'b0;
   bit         cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // True sequence values mod 256, term n = value at sample index n of a fresh run.
   task automatic build_terms();
      for (int n = 0; n < 1024; n++) begin
         term[0][n] = (n * n) % 256;
         term[1][n] = (n == 0) ? 1 : (term[1][n > 0 ? n - 1 : 0] * 3) % 256;
         term[2][n] = (n * (n + 1) / 2) % 256;
         if (n < 2) begin
            term[3][n] = 1;
            term[4][n] = n;
            term[5][n] = 2 - n;
         end else begin
            term[3][n] = (term[3][n-1] + term[3][n-2]) % 256;
            term[4][n] = (2 * term[4][n-1] + term[4][n-2]) % 256;
            term[5][n] = (term[5][n-1] + term[5][n-2]) % 256;
         end
         if (n < 3) term[6][n] = 1;
         else       term[6][n] = (term[6][n-2] + term[6][n-3]) % 256;
         if (n == 0) term[7][n] = 2;
         else        term[7][n] = (term[7][n-1] * term[7][n-1] - term[7][n-1] + 1) % 256;
      end
   endtask

   task automatic model_step(input bit rst, input bit clr, input bit v, input logic [7:0] x);
      if (rst || clr) begin
         n_seen   = 0;
         alive[0] = masks[0];
         alive[1] = masks[1];
      end
      if (!rst && v) begin
         for (int m = 0; m < 2; m++)
            for (int i = 0; i < 8; i++)
               if (int'(x) != term[i][n_seen]) alive[m][i] = 1'b0;
         if (n_seen < 1023) n_seen++;
      end
      exp_upd = !rst && v;
   endtask

   task automatic drive(input bit rst, input bit clr, input bit v, input logic [7:0] x);
      @(negedge clk);
      reset    = rst;
      clear    = clr;
      in_valid = v;
      in_data  = x;
      model_step(rst, clr, v, x);
      cmp_en = 1'b1;
   endtask

   task automatic feed(input logic [7:0] x);
      drive(1'b0, 1'b0, 1'b1, x);
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   task automatic cmp_inst(input int m, input logic [7:0] c, input logic l, input logic [2:0] sid,
                           input logic nm, input logic [1:0] st, input logic u,
                           input logic pv, input logic [7:0] pd);
      int pop, e_id, e_st, e_pd;
      bit seen, e_lock;
      pop    = $countones(alive[m]);
      seen   = (n_seen > 0);
      e_lock = seen && (pop == 1);
      e_id   = 0;
      for (int i = 0; i < 8; i++) if (e_lock && alive[m][i]) e_id = i;
      e_st = !seen ? 0 : (pop == 0) ? 3 : (pop == 1) ? 2 : 1;
      check($sformatf("cand[%0d]", m), c, alive[m]);
      check($sformatf("locked[%0d]", m), l, e_lock);
      check($sformatf("seq_id[%0d]", m), sid, e_id);
      check($sformatf("nomatch[%0d]", m), nm, seen && pop == 0);
      check($sformatf("state[%0d]", m), st, e_st);
      check($sformatf("upd[%0d]", m), u, exp_upd);
`ifdef SEQ_CLASSIFIER_PREDICT_EN
      e_pd = e_lock ? term[e_id][n_seen] : 0;
      check($sformatf("pred_valid[%0d]", m), pv, e_lock);
      check($sformatf("pred_data[%0d]", m), pd, e_pd);
`else
      e_pd = 0;
      check($sformatf("pred_valid[%0d]", m), pv, 1'b0);
      check($sformatf("pred_data[%0d]", m), pd, e_pd);
`endif
   endtask

   always @(posedge clk) begin
      #2;
      if (cmp_en) begin
         cmp_inst(0, cand_a, locked_a, seq_id_a, nomatch_a, state_a, upd_a, pv_a, pd_a);
         cmp_inst(1, cand_b, locked_b, seq_id_b, nomatch_b, state_b, upd_b, pv_b, pd_b);
      end
   end

   initial begin
      bit         v, clr, rst;
      logic [7:0] x;
      int         sel;

      build_terms();
      model_step(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      settle();
      check("reset cand", cand_a, 8'hFF);
      check("reset state", state_a, 2'd0);
      check("reset locked", locked_a, 1'b0);
      check("reset upd", upd_a, 1'b0);

      // Fibonacci locks after its third sample; the F7 instance has it masked off
      feed(8'd1); settle(); check("fib cand0", cand_a, 8'h4A);
      feed(8'd1); settle(); check("fib cand1", cand_a, 8'h48);
      feed(8'd2); settle(); check("fib cand2", cand_a, 8'h08);
      check("fib locked", locked_a, 1'b1);
      check("fib seq_id", seq_id_a, 3'd3);
      check("mask F7 cand", cand_b, 8'h00);
      check("mask F7 nomatch", nomatch_b, 1'b1);
`ifdef SEQ_CLASSIFIER_PREDICT_EN
      check("fib pred", pd_a, 8'd3);
`endif
      feed(8'd3); feed(8'd5); settle();
      check("fib held seq_id", seq_id_a, 3'd3);
      check("fib held upd", upd_a, 1'b1);

      drive(1'b0, 1'b1, 1'b0, 8'h00);
      feed(8'd0); settle(); check("sqr cand0", cand_a, 8'h15);
      feed(8'd1); settle(); check("sqr cand1", cand_a, 8'h15);
      feed(8'd4); settle(); check("sqr cand2", cand_a, 8'h01);
      check("sqr state", state_a, 2'd2);

      drive(1'b0, 1'b1, 1'b0, 8'h00);
      feed(8'd2); settle(); check("sylv cand0", cand_a, 8'hA0);
      feed(8'd3); settle(); check("sylv cand1", cand_a, 8'h80);
      check("sylv seq_id", seq_id_a, 3'd7);
      feed(8'd7); feed(8'd43); feed(8'd15); settle();
      check("sylv held", cand_a, 8'h80);
      feed(8'd16); settle();
      check("sylv fail cand", cand_a, 8'h00);
      check("sylv fail nomatch", nomatch_a, 1'b1);
      check("sylv fail state", state_a, 2'd3);
      check("sylv fail locked", locked_a, 1'b0);

      // Clear on its own, then clear coincident with the first sample of the new run
      for (int rep = 0; rep < 2; rep++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         feed(8'd0); feed(8'd0); feed(8'd0);
         if (rep == 0) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00); settle();
            check("clear cand", cand_a, 8'hFF);
            check("clear state", state_a, 2'd0);
            feed(8'd2);
         end else begin
            drive(1'b0, 1'b1, 1'b1, 8'd2);
         end
         settle(); check($sformatf("luc cand0 rep%0d", rep), cand_a, 8'hA0);
         feed(8'd1); settle(); check($sformatf("luc cand1 rep%0d", rep), cand_a, 8'h20);
         feed(8'd3); settle(); check($sformatf("luc cand2 rep%0d", rep), cand_a, 8'h20);
         check($sformatf("luc seq_id rep%0d", rep), seq_id_a, 3'd5);
      end

      // Squares across the index wrap
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int k = 0; k <= 300; k++) begin
         feed(8'((k * k) % 256));
         if (k == 256) begin
            settle();
            check("wrap cand", cand_a, 8'h01);
         end
      end
      settle();
      check("post-wrap cand", cand_a, 8'h01);
      check("post-wrap state", state_a, 2'd2);

      // Reset while locked with a sample presented
      drive(1'b1, 1'b0, 1'b1, 8'h55); settle();
      check("midrun reset cand", cand_a, 8'hFF);
      check("midrun reset state", state_a, 2'd0);
      check("midrun reset locked", locked_a, 1'b0);
      check("midrun reset upd", upd_a, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 8'h00);

      sel = 0;
      for (int c = 0; c < 1500; c++) begin
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 63) == 0) || (n_seen > 900);
         rst = ($urandom_range(0, 299) == 0);
         if (clr || rst) sel = $urandom_range(0, 7);
         x = 8'(term[sel][(clr || rst) ? 0 : n_seen]);
         if ($urandom_range(0, 39) == 0) x = 8'($urandom);
         drive(rst, clr, v, x);
      end

      drive(1'b0, 1'b0, 1'b0, 8'h00);
      settle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
